// File: rtl/mp_alu_seq.sv
// mp_alu_seq: multi-precision add/subtract sequencer around one 16-bit ALU.
// Operand word pairs stream in low word first; the carry chains between
// words and result words leave through a one-entry output buffer.
// Optional feature macro: MP_SEQ_CARRY_IN_EN (adds cin_ext for ADC/SBC chains).
module mp_alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_sub,
    input  logic [2:0]  num_words,
`ifdef MP_SEQ_CARRY_IN_EN
    input  logic        cin_ext,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [3:0]  nzvc
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t      state, state_nxt;
    logic        sub_q;
    logic [3:0]  len_q;      // 1..8
    logic [3:0]  cnt_q;      // words accepted so far
    logic        carry_q;
    logic        z_acc;
    logic [3:0]  stage_q;    // flags held until the last word leaves
`ifdef MP_SEQ_CARRY_IN_EN
    logic        cin_ext_q;
`endif

    logic        in_fire, out_fire, start_fire, flush_done;
    logic        first_word, last_word;

    // ALU signals
    logic [15:0] alu_b;
    logic        alu_cin_en, alu_cin, alu_cin_eff;
    logic [16:0] alu_sum;
    logic        alu_n, alu_z, alu_v, alu_c;

    assign first_word = (cnt_q == 4'd0);
    assign last_word  = (cnt_q == len_q - 4'd1);
    assign in_ready   = (state == RUN) && (cnt_q != len_q) && (!out_valid || out_ready);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign start_fire = (state == IDLE) && start;
    assign flush_done = (state == FLUSH) && out_fire && out_last;
    assign busy       = (state != IDLE);

    // Carry-in selection: first word uses the op default unless an external carry is chained
    always_comb begin
        alu_cin_en = !first_word;
        alu_cin    = carry_q;
`ifdef MP_SEQ_CARRY_IN_EN
        if (first_word) begin
            alu_cin_en = 1'b1;
            alu_cin    = cin_ext_q;
        end
`endif
    end

    // 16-bit ALU; with carry disabled, subtract behaves as "no borrow in"
    assign alu_b       = sub_q ? ~in_b : in_b;
    assign alu_cin_eff = alu_cin_en ? alu_cin : sub_q;
    assign alu_sum     = {1'b0, in_a} + {1'b0, alu_b} + {16'd0, alu_cin_eff};
    assign alu_c       = alu_sum[16];
    assign alu_n       = alu_sum[15];
    assign alu_z       = (alu_sum[15:0] == 16'd0);
    assign alu_v       = (in_a[15] == alu_b[15]) && (alu_sum[15] != in_a[15]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (in_fire && last_word) state_nxt = FLUSH;
            FLUSH:   if (flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operation context, word datapath, output buffer and flag reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q     <= 1'b0;
            len_q     <= 4'd0;
            cnt_q     <= 4'd0;
            carry_q   <= 1'b0;
            z_acc     <= 1'b1;
            stage_q   <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= 16'd0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            nzvc      <= 4'd0;
`ifdef MP_SEQ_CARRY_IN_EN
            cin_ext_q <= 1'b0;
`endif
        end else begin
            done <= flush_done;
            if (start_fire) begin
                sub_q   <= op_sub;
                len_q   <= (num_words == 3'd0) ? 4'd8 : {1'b0, num_words};
                cnt_q   <= 4'd0;
                carry_q <= 1'b0;
                z_acc   <= 1'b1;
`ifdef MP_SEQ_CARRY_IN_EN
                cin_ext_q <= cin_ext;
`endif
            end
            if (in_fire) begin
                out_data  <= alu_sum[15:0];
                out_valid <= 1'b1;
                out_last  <= last_word;
                carry_q   <= alu_c;
                z_acc     <= z_acc & alu_z;
                cnt_q     <= cnt_q + 4'd1;
                if (last_word)
                    stage_q <= {alu_n, z_acc & alu_z, alu_v, alu_c};
            end else if (out_fire) begin
                out_valid <= 1'b0;
                if (flush_done) out_last <= 1'b0;
            end
            if (flush_done)
                nzvc <= stage_q;
        end
    end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Directed self-checking bench for mp_alu_seq.
module tb_mp_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [2:0]  num_words = 3'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [3:0]  nzvc;
`ifdef MP_SEQ_CARRY_IN_EN
    logic        cin_ext = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    mp_alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .num_words(num_words),
`ifdef MP_SEQ_CARRY_IN_EN
        .cin_ext(cin_ext),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .nzvc(nzvc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start(input string tag, input logic sub, input logic [2:0] n);
        start = 1'b1; op_sub = sub; num_words = n;
        tick();
        start = 1'b0;
        chk({tag, " busy"}, busy, 1);
    endtask

    // Present one operand pair (consumer ready) and check the resulting word
    task automatic xfer(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input logic exp_l);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b;
        #0;
        chk({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " out_data"}, out_data, exp_d);
        chk({tag, " out_last"}, out_last, exp_l);
    endtask

    // Drain the last word and wait (bounded) for the done pulse
    task automatic finish_op(input string tag, input logic [3:0] exp_nzvc);
        bit seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        chk({tag, " done"}, seen, 1);
        chk({tag, " nzvc"}, nzvc, exp_nzvc);
        chk({tag, " busy_clr"}, busy, 0);
        chk({tag, " out_valid_clr"}, out_valid, 0);
        tick();
        chk({tag, " done_once"}, done, 0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_last", out_last, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst nzvc", nzvc, 0);
        rst = 1'b0;
        tick();

        // Add with carry across words: 0x0001_FFFF + 0x0000_0001
        do_start("add2", 1'b0, 3'd2);
        xfer("add2 w0", 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        xfer("add2 w1", 16'h0001, 16'h0000, 16'h0002, 1'b1);
        finish_op("add2", 4'b0000);

        // Subtract: 0x0003_0005 - 0x0001_0002 = 0x0002_0003, no borrow
        do_start("sub2", 1'b1, 3'd2);
        xfer("sub2 w0", 16'h0005, 16'h0002, 16'h0003, 1'b0);
        xfer("sub2 w1", 16'h0003, 16'h0001, 16'h0002, 1'b1);
        finish_op("sub2", 4'b0001);

        // Signed overflow on a single word
        do_start("ovf", 1'b0, 3'd1);
        xfer("ovf w0", 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
        finish_op("ovf", 4'b1010);

        // Zero result with a 4-cycle consumer stall on the second word
        do_start("zero", 1'b0, 3'd3);
        xfer("zero w0", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        xfer("zero w1", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h0000; in_b = 16'h0000;
        start = 1'b1; op_sub = 1'b1; num_words = 3'd1;   // must be ignored
        for (int i = 0; i < 4; i++) begin
            #0;
            chk("stall in_ready", in_ready, 0);
            tick();
            chk("stall out_valid", out_valid, 1);
            chk("stall out_data", out_data, 16'h0000);
            chk("stall out_last", out_last, 0);
        end
        start = 1'b0; in_valid = 1'b0;
        xfer("zero w2", 16'h0000, 16'h0000, 16'h0000, 1'b1);
        finish_op("zero", 4'b0100);

        // Reset mid-operation clears everything at once
        do_start("rstm", 1'b0, 3'd4);
        xfer("rstm w0", 16'h0001, 16'h0001, 16'h0002, 1'b0);
        xfer("rstm w1", 16'h0001, 16'h0001, 16'h0002, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstm in_ready", in_ready, 0);
        chk("rstm out_valid", out_valid, 0);
        chk("rstm busy", busy, 0);
        chk("rstm nzvc", nzvc, 0);
        tick();
        rst = 1'b0;
        tick();
        do_start("fresh", 1'b0, 3'd1);
        xfer("fresh w0", 16'h0001, 16'h0001, 16'h0002, 1'b1);
        finish_op("fresh", 4'b0000);

`ifdef MP_SEQ_CARRY_IN_EN
        // External carry into the first word
        cin_ext = 1'b1;
        do_start("cin", 1'b0, 3'd1);
        cin_ext = 1'b0;
        xfer("cin w0", 16'h0001, 16'h0001, 16'h0003, 1'b1);
        finish_op("cin", 4'b0000);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
